fft_butterfly: RTL and testbench

Pipelined radix-2 decimation-in-time butterfly for the 256-point FFT in the spectral-flux beat detector. The block computes X = A + W·B and Y = A − W·B, with optional divide-by-2 scaling per stage. The twiddle factor W arrives from the twiddle ROM as Q1.14 values (16384 = 1.0, W^n = cos − j·sin). The FFT stage sequencer feeds the block, which writes results back to the ping-pong sample RAM through a valid/ready handshake with stall.

---
 rtl/fft_pkg.sv | 50 +++++
 rtl/fft_cmul.sv | 44 ++++
 rtl/fft_butterfly.sv | 145 ++++++++++++++
 tb/tb_fft_butterfly.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT datapath.
// Butterfly helpers: round-half-up halving and DATA_W reduction.
package fft_pkg;

    localparam int DATA_W  = 16;
    localparam int TW_W    = 16;
    localparam int TW_FRAC = 14;
    localparam int PROD_W  = DATA_W + TW_W;
    localparam int EXT_W   = DATA_W + 2;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } tw_t;

    typedef logic signed [EXT_W-1:0] ext_t;

    localparam ext_t DMAX = ext_t'(2 ** (DATA_W - 1) - 1);
    localparam ext_t DMIN = ext_t'(-(2 ** (DATA_W - 1)));

    function automatic ext_t half_round(input ext_t s, input logic sc);
        logic signed [EXT_W:0] t;
        t = (EXT_W + 1)'(s);
        t = t + (EXT_W + 1)'(1);
        return sc ? ext_t'(t >>> 1) : s;
    endfunction

    function automatic logic out_of_range(input ext_t s);
        return (s > DMAX) || (s < DMIN);
    endfunction

    function automatic logic [DATA_W-1:0] clamp(input ext_t s);
        if (s > DMAX)
            return DMAX[DATA_W-1:0];
        else if (s < DMIN)
            return DMIN[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] wrap(input ext_t s);
        return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// Complex multiply B*W: registered partial products (stage 2),
// then rounded Q1.14 reduction to DATA_W+2 bits.
module fft_cmul
    import fft_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  cplx_t b,
    input  tw_t   w,
    output ext_t  t_re,
    output ext_t  t_im
);

    localparam logic signed [PROD_W:0] RND =
        (PROD_W + 1)'(2 ** (TW_FRAC - 1));

    logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PROD_W:0]   sum_re, sum_im;

    // Stage 2: four signed partial products, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (en) begin
            p_rr <= PROD_W'(b.re) * PROD_W'(w.re);
            p_ii <= PROD_W'(b.im) * PROD_W'(w.im);
            p_ri <= PROD_W'(b.re) * PROD_W'(w.im);
            p_ir <= PROD_W'(b.im) * PROD_W'(w.re);
        end
    end

    // Combine products, add half an LSB, drop the fraction
    always_comb begin
        sum_re = (PROD_W + 1)'(p_rr) - (PROD_W + 1)'(p_ii) + RND;
        sum_im = (PROD_W + 1)'(p_ri) + (PROD_W + 1)'(p_ir) + RND;
        t_re   = ext_t'(sum_re >>> TW_FRAC);
        t_im   = ext_t'(sum_im >>> TW_FRAC);
    end

endmodule

// File: rtl/fft_butterfly.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B.
// Define BFLY_SAT_EN for saturation and sticky o_ovf; default wraps.
module fft_butterfly
    import fft_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_a_re,
    input  logic [DATA_W-1:0] i_a_im,
    input  logic [DATA_W-1:0] i_b_re,
    input  logic [DATA_W-1:0] i_b_im,
    input  logic [TW_W-1:0]   i_tw_re,
    input  logic [TW_W-1:0]   i_tw_im,
    input  logic              i_scale,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_x_re,
    output logic [DATA_W-1:0] o_x_im,
    output logic [DATA_W-1:0] o_y_re,
    output logic [DATA_W-1:0] o_y_im,
    output logic              o_ovf,
    input  logic              i_ovf_clr
);

    logic  advance;
    logic  v1, v2, sc1, sc2;
    cplx_t a1, b1, a2;
    tw_t   w1;
    ext_t  t_re, t_im;
    ext_t  a_re_e, a_im_e;
    ext_t  s_xre, s_xim, s_yre, s_yim;
    logic [DATA_W-1:0] r_xre, r_xim, r_yre, r_yim;

    assign advance = i_ready | ~o_valid;
    assign o_ready = advance;

    // Stage 1: capture operands, twiddle and scale with the beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1  <= 1'b0;
            sc1 <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            w1  <= '0;
        end else if (advance) begin
            v1  <= i_valid;
            sc1 <= i_scale;
            a1  <= '{re: i_a_re, im: i_a_im};
            b1  <= '{re: i_b_re, im: i_b_im};
            w1  <= '{re: i_tw_re, im: i_tw_im};
        end
    end

    fft_cmul u_cmul (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (advance),
        .b     (b1),
        .w     (w1),
        .t_re  (t_re),
        .t_im  (t_im)
    );

    // Stage 2: delay A, scale and valid alongside the products
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v2  <= 1'b0;
            sc2 <= 1'b0;
            a2  <= '0;
        end else if (advance) begin
            v2  <= v1;
            sc2 <= sc1;
            a2  <= a1;
        end
    end

    // Stage 3 arithmetic: a +/- t, then optional rounded halving
    always_comb begin
        a_re_e = ext_t'(a2.re);
        a_im_e = ext_t'(a2.im);
        s_xre  = half_round(a_re_e + t_re, sc2);
        s_xim  = half_round(a_im_e + t_im, sc2);
        s_yre  = half_round(a_re_e - t_re, sc2);
        s_yim  = half_round(a_im_e - t_im, sc2);
    end

`ifdef BFLY_SAT_EN
    logic ovf_hit;

    // Clamp each result to DATA_W and flag any that needed it
    always_comb begin
        r_xre   = clamp(s_xre);
        r_xim   = clamp(s_xim);
        r_yre   = clamp(s_yre);
        r_yim   = clamp(s_yim);
        ovf_hit = out_of_range(s_xre) | out_of_range(s_xim) |
                  out_of_range(s_yre) | out_of_range(s_yim);
    end

    // Sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_ovf <= 1'b0;
        else if (advance && v2 && ovf_hit)
            o_ovf <= 1'b1;
        else if (i_ovf_clr)
            o_ovf <= 1'b0;
    end
`else
    logic ovf_clr_unused;

    // Two's-complement wrap to DATA_W
    always_comb begin
        r_xre = wrap(s_xre);
        r_xim = wrap(s_xim);
        r_yre = wrap(s_yre);
        r_yim = wrap(s_yim);
    end

    assign o_ovf          = 1'b0;
    assign ovf_clr_unused = i_ovf_clr;
`endif

    // Output stage: data only moves when a valid beat lands
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_x_re  <= '0;
            o_x_im  <= '0;
            o_y_re  <= '0;
            o_y_im  <= '0;
        end else if (advance) begin
            o_valid <= v2;
            if (v2) begin
                o_x_re <= r_xre;
                o_x_im <= r_xim;
                o_y_re <= r_yre;
                o_y_im <= r_yim;
            end
        end
    end

endmodule

// File: tb/tb_fft_butterfly.sv
// Self-checking bench for fft_butterfly against an integer model.
// Works with and without BFLY_SAT_EN.
module tb_fft_butterfly;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_a_re = '0, i_a_im = '0;
    logic [15:0] i_b_re = '0, i_b_im = '0;
    logic [15:0] i_tw_re = '0, i_tw_im = '0;
    logic        i_scale = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] o_x_re, o_x_im, o_y_re, o_y_im;
    logic        o_ovf;
    logic        i_ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int ar, ai, br, bi, wr, wi;
        bit sc;
    } beat_t;

    typedef struct {
        int xr, xi, yr, yi;
        bit ovf;
    } exp_t;

    always #5 i_clk = ~i_clk;

    fft_butterfly dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_a_re    (i_a_re),
        .i_a_im    (i_a_im),
        .i_b_re    (i_b_re),
        .i_b_im    (i_b_im),
        .i_tw_re   (i_tw_re),
        .i_tw_im   (i_tw_im),
        .i_scale   (i_scale),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_x_re    (o_x_re),
        .o_x_im    (o_x_im),
        .o_y_re    (o_y_re),
        .o_y_im    (o_y_im),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    function automatic longint wrapn(longint v, int bits);
        longint m;
        m = longint'(1) << bits;
        v = v % m;
        if (v < 0) v = v + m;
        if (v >= m / 2) v = v - m;
        return v;
    endfunction

    function automatic exp_t model(beat_t b);
        longint tr, ti;
        longint s[4];
        int     r[4];
        exp_t   e;
        bit     o;
        o  = 1'b0;
        tr = longint'(b.br) * b.wr - longint'(b.bi) * b.wi + 8192;
        ti = longint'(b.br) * b.wi + longint'(b.bi) * b.wr + 8192;
        tr = wrapn(tr >>> 14, 18);
        ti = wrapn(ti >>> 14, 18);
        s[0] = wrapn(b.ar + tr, 18);
        s[1] = wrapn(b.ai + ti, 18);
        s[2] = wrapn(b.ar - tr, 18);
        s[3] = wrapn(b.ai - ti, 18);
        for (int k = 0; k < 4; k++) begin
            if (b.sc) s[k] = (s[k] + 1) >>> 1;
`ifdef BFLY_SAT_EN
            if (s[k] > 32767) begin
                r[k] = 32767;
                o = 1'b1;
            end else if (s[k] < -32768) begin
                r[k] = -32768;
                o = 1'b1;
            end else begin
                r[k] = int'(s[k]);
            end
`else
            r[k] = int'(wrapn(s[k], 16));
`endif
        end
        e.xr = r[0];
        e.xi = r[1];
        e.yr = r[2];
        e.yi = r[3];
        e.ovf = o;
        return e;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.ar = rnd16();
        b.ai = rnd16();
        b.br = rnd16();
        b.bi = rnd16();
        b.wr = rnd16();
        b.wi = rnd16();
        b.sc = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic drive(beat_t b);
        i_a_re  = 16'(b.ar);
        i_a_im  = 16'(b.ai);
        i_b_re  = 16'(b.br);
        i_b_im  = 16'(b.bi);
        i_tw_re = 16'(b.wr);
        i_tw_im = 16'(b.wi);
        i_scale = b.sc;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        @(negedge i_clk);
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: valid=%b ready=%b ovf=%b want 0 1 0",
                     o_valid, o_ready, o_ovf);
        end
        n_cmp++;
        if ({o_x_re, o_x_im, o_y_re, o_y_im} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0",
                     {o_x_re, o_x_im, o_y_re, o_y_im});
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_directed();
        beat_t bt[6];
        int    ex[6][4];
        bit    eo[6];
        int    lat;
        bit    got;
        bt[0] = '{1000, 0, 1000, 0, 16384, 0, 1'b0};
        ex[0] = '{2000, 0, 0, 0};
        bt[1] = '{1000, 0, 1000, 0, 0, -16384, 1'b0};
        ex[1] = '{1000, -1000, 1000, 1000};
        bt[2] = '{2, 0, 1, 0, 16384, 0, 1'b1};
        ex[2] = '{2, 0, 1, 0};
        bt[3] = '{-2, 0, -1, 0, 16384, 0, 1'b1};
        ex[3] = '{-1, 0, 0, 0};
        bt[4] = '{30000, 0, 30000, 0, 16384, 0, 1'b0};
        bt[5] = '{30000, 0, 30000, 0, 16384, 0, 1'b1};
        ex[5] = '{30000, 0, 0, 0};
        eo[0] = 1'b0;
        eo[1] = 1'b0;
        eo[2] = 1'b0;
        eo[3] = 1'b0;
`ifdef BFLY_SAT_EN
        ex[4] = '{32767, 0, 0, 0};
        eo[4] = 1'b1;
        eo[5] = 1'b1;
`else
        ex[4] = '{-5536, 0, 0, 0};
        eo[4] = 1'b0;
        eo[5] = 1'b0;
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            drive(bt[i]);
            i_valid = 1'b1;
            i_ready = 1'b1;
            @(negedge i_clk);
            i_valid = 1'b0;
            lat = 1;
            got = 1'b0;
            while (!got && lat < 12) begin
                if (o_valid) got = 1'b1;
                else begin
                    @(negedge i_clk);
                    lat++;
                end
            end
            n_cmp++;
            if (lat != 3) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d want 3", i, lat);
            end
            n_cmp++;
            if ({o_x_re, o_x_im, o_y_re, o_y_im} !==
                {16'(ex[i][0]), 16'(ex[i][1]), 16'(ex[i][2]), 16'(ex[i][3])}) begin
                n_fail++;
                $display("FAIL dir%0d_xy: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                         i, $signed(o_x_re), $signed(o_x_im),
                         $signed(o_y_re), $signed(o_y_im),
                         ex[i][0], ex[i][1], ex[i][2], ex[i][3]);
            end
            n_cmp++;
            if (o_ovf !== eo[i]) begin
                n_fail++;
                $display("FAIL dir%0d_ovf: got %b want %b", i, o_ovf, eo[i]);
            end
        end
    endtask

    task automatic test_ovf_clear();
        beat_t b;
        bit    got;
        int    k;
        b = '{30000, 0, 30000, 0, 16384, 0, 1'b0};
        @(negedge i_clk);
        i_ovf_clr = 1'b1;
        @(negedge i_clk);
        i_ovf_clr = 1'b0;
        n_cmp++;
        if (o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", o_ovf);
        end
        i_ovf_clr = 1'b1;
        drive(b);
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < 12) begin
            @(negedge i_clk);
            k++;
            if (o_valid) got = 1'b1;
        end
        n_cmp++;
`ifdef BFLY_SAT_EN
        if (!got || o_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_wins: valid=%b ovf=%b want 1 1", got, o_ovf);
        end
`else
        if (!got || o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_tied: valid=%b ovf=%b want 1 0", got, o_ovf);
        end
`endif
        @(negedge i_clk);
        n_cmp++;
        if (o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear_after: got %b want 0", o_ovf);
        end
        i_ovf_clr = 1'b0;
    endtask

    task automatic test_backpressure(input int n);
        exp_t        q[$];
        exp_t        e;
        beat_t       b;
        logic [63:0] held;
        bit          stalled;
        bit          sticky;
        int          sent, recv, cyc;
        stalled = 1'b0;
        sticky = 1'b0;
        sent = 0;
        recv = 0;
        cyc = 0;
        held = '0;
        @(negedge i_clk);
        i_ovf_clr = 1'b1;
        @(negedge i_clk);
        i_ovf_clr = 1'b0;
        while (recv < n && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            if (o_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_spurious: output with nothing pending");
                end else begin
                    e = q[0];
                    sticky = sticky | e.ovf;
                    if ({o_x_re, o_x_im, o_y_re, o_y_im} !==
                        {16'(e.xr), 16'(e.xi), 16'(e.yr), 16'(e.yi)}) begin
                        n_fail++;
                        $display("FAIL bp_beat%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                                 recv, $signed(o_x_re), $signed(o_x_im),
                                 $signed(o_y_re), $signed(o_y_im),
                                 e.xr, e.xi, e.yr, e.yi);
                    end
                end
                if (stalled) begin
                    n_cmp++;
                    if ({o_x_re, o_x_im, o_y_re, o_y_im} !== held) begin
                        n_fail++;
                        $display("FAIL bp_stall_hold: got %h want %h",
                                 {o_x_re, o_x_im, o_y_re, o_y_im}, held);
                    end
                end
            end
            n_cmp++;
            if (o_ovf !== sticky) begin
                n_fail++;
                $display("FAIL bp_ovf: got %b want %b", o_ovf, sticky);
            end
            i_ready = 1'($urandom_range(0, 1));
            if (sent < n && $urandom_range(0, 3) != 0) begin
                b = rnd_beat();
                drive(b);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (o_ready !== (i_ready | ~o_valid)) begin
                n_fail++;
                $display("FAIL bp_ready: got %b want %b", o_ready,
                         i_ready | ~o_valid);
            end
            if (i_valid && o_ready) begin
                q.push_back(model(b));
                sent++;
            end
            if (o_valid && i_ready && q.size() > 0) begin
                void'(q.pop_front());
                recv++;
            end
            stalled = o_valid & ~i_ready;
            held = {o_x_re, o_x_im, o_y_re, o_y_im};
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_cmp++;
        if (recv != n || q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pending %0d want %0d pending 0",
                     recv, q.size(), n);
        end
    endtask

    task automatic test_reset_midstream();
        beat_t b;
        exp_t  q[$];
        exp_t  e;
        int    seen;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            b = '{111 * (i + 1), 0, 7, 0, 16384, 0, 1'b0};
            drive(b);
            i_valid = 1'b1;
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefill: valid=%b want 1", o_valid);
        end
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 ||
            {o_x_re, o_x_im, o_y_re, o_y_im} !== 64'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b ready=%b data=%h want 0 1 0",
                     o_valid, o_ready, {o_x_re, o_x_im, o_y_re, o_y_im});
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b = rnd_beat();
            drive(b);
            i_valid = 1'b1;
            q.push_back(model(b));
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (o_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mid_stale: extra output %0d", $signed(o_x_re));
                end else begin
                    e = q.pop_front();
                    if ({o_x_re, o_x_im, o_y_re, o_y_im} !==
                        {16'(e.xr), 16'(e.xi), 16'(e.yr), 16'(e.yi)}) begin
                        n_fail++;
                        $display("FAIL mid_beat%0d: got %0d %0d want %0d %0d",
                                 seen, $signed(o_x_re), $signed(o_y_re),
                                 e.xr, e.yr);
                    end
                end
                seen++;
            end
            @(negedge i_clk);
        end
        n_cmp++;
        if (seen != 2) begin
            n_fail++;
            $display("FAIL mid_count: got %0d want 2", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ovf_clear();
        test_backpressure(40);
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
